// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: op encodings, FSM states
// and the request payload carried from the winning requester into the ALU registers.
package alu_pkg;

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] a;
        logic [1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between client blocks (master) and the ALU sharing controller (slave).
// Requester i owns bits [2i+1:2i] of req_sel/req_a/req_b.
interface alu_share_ctrl_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_sel;
    logic [2*NUM_REQ-1:0] req_a;
    logic [2*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [3:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request at or
// above ptr, wrapping modulo NUM_REQ. The caller decides when a grant is consumed.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop; any path leaving a
        // combinational output unassigned would infer a latch.
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external 2-bit ALU among NUM_REQ requesters: round-robin grant, registered
// operands, tagged response. Define ALU_SHARE_STATS_EN to add the stat_ops/stat_stall counters.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_ctrl_if.slave bus,
    output logic [1:0]      alu_sel,
    output logic [1:0]      alu_a,
    output logic [1:0]      alu_b,
    input  logic [3:0]      alu_y,
    output logic            busy
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [7:0]      stat_ops,
    output logic [7:0]      stat_stall
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    arb_id;
    logic [ID_W-1:0]    rsp_id_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_any;
    logic               accept;
    logic               rsp_valid_q;
    logic [3:0]         rsp_data_q;
    alu_req_t           pick;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .any   (arb_any)
    );

    assign pick = '{sel: bus.req_sel[{arb_id, 1'b0} +: 2],
                    a:   bus.req_a[{arb_id, 1'b0} +: 2],
                    b:   bus.req_b[{arb_id, 1'b0} +: 2]};

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (arb_any && !rst) begin
                    accept        = 1'b1;
                    bus.req_ready = arb_grant;
                    state_nxt     = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The alu_* registers change only on an accept, so the ALU sees stable inputs otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sel     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            cur_id      <= '0;
            rr_ptr      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_sel <= pick.sel;
                        alu_a   <= pick.a;
                        alu_b   <= pick.b;
                        cur_id  <= arb_id;
                        rr_ptr  <= (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + ID_W'(1);
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_y;
                    rsp_id_q    <= cur_id;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != IDLE);

`ifdef ALU_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid_q && bus.rsp_ready && stat_ops != 8'hFF)
                stat_ops <= stat_ops + 8'd1;
            if (state == RESP && !bus.rsp_ready && stat_stall != 8'hFF)
                stat_stall <= stat_stall + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a queue-based scoreboard filled at grant time and a
// negedge monitor that pops on every response handshake. Stats checks need ALU_SHARE_STATS_EN.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    typedef struct {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] alu_sel;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [3:0] alu_y;
    logic       busy;
`ifdef ALU_SHARE_STATS_EN
    logic [7:0] stat_ops;
    logic [7:0] stat_stall;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    alu_share_ctrl_if #(.NUM_REQ(4)) bus ();

    alu_share_ctrl #(.NUM_REQ(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_y   (alu_y),
        .busy    (busy)
`ifdef ALU_SHARE_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // External combinational ALU: every op yields a 2-bit result, zero-extended to 4 bits.
    function automatic logic [3:0] alu_model(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        case (s)
            OP_NOT:  r = ~a;
            OP_NAND: r = ~(a & b);
            OP_ADD:  r = a + b;
            default: r = a * b;
        endcase
        return {2'b00, r};
    endfunction

    assign alu_y = alu_model(alu_sel, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a response is consumed on the edge after rsp_valid&rsp_ready is seen.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d data=%b, required no response", bus.rsp_id, bus.rsp_data);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            end
        end
    end

    task automatic expect_rsp(input logic [1:0] eid, input logic [3:0] edata);
        exp_t e;
        e.id   = eid;
        e.data = edata;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] sel, input logic [1:0] a, input logic [1:0] b);
        bus.req_sel[2*i +: 2] = sel;
        bus.req_a[2*i +: 2]   = a;
        bus.req_b[2*i +: 2]   = b;
    endtask

    // Waits (bounded) for a grant, compares it, lets the accept edge pass and drops that request.
    task automatic wait_grant(input logic [3:0] exp_gnt, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant"}, 32'(bus.req_ready), 32'(exp_gnt));
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~exp_gnt;
    endtask

    task automatic wait_rsp_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        check("idle_no_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;

        // Single ADD from requester 2: 3+2 truncated to 2 bits
        bus.rsp_ready = 1'b1;
        set_req(2, OP_ADD, 2'd3, 2'd2);
        bus.req_valid = 4'b0100;
        expect_rsp(2'd2, 4'b0001);
        wait_grant(4'b0100, "t1");
        @(negedge clk);
        check("t1_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t1_exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_latency_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        drain("t1_drain");

        // All four valid from reset: grants rotate 0,1,2,3
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, OP_MUL, 2'd3, 2'd3);
        set_req(1, OP_NAND, 2'd3, 2'd3);
        set_req(2, OP_NOT, 2'd3, 2'd3);
        set_req(3, OP_ADD, 2'd3, 2'd3);
        expect_rsp(2'd0, 4'b0001);
        expect_rsp(2'd1, 4'b0000);
        expect_rsp(2'd2, 4'b0000);
        expect_rsp(2'd3, 4'b0010);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) wait_grant(4'(1 << i), "t2");
        drain("t2_drain");

        // Back-pressure: response held stable, requester 1 waits for the handshake
        bus.rsp_ready = 1'b0;
        set_req(0, OP_ADD, 2'd1, 2'd1);
        expect_rsp(2'd0, 4'b0010);
        bus.req_valid = 4'b0001;
        wait_grant(4'b0001, "t3_r0");
        set_req(1, OP_NAND, 2'd1, 2'd2);
        expect_rsp(2'd1, 4'b0011);
        bus.req_valid = 4'b0010;
        wait_rsp_valid("t3_rsp_valid");
        check("t3_alu_hold", 32'({alu_sel, alu_a, alu_b}), 32'({OP_ADD, 2'd1, 2'd1}));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("t3_stall_data", 32'(bus.rsp_data), 32'd2);
            check("t3_stall_id", 32'(bus.rsp_id), 32'd0);
            check("t3_stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_grant(4'b0010, "t3_r1");
        drain("t3_drain");

        // Wrap: after a grant to 3 with 0 and 3 both valid, 0 wins next
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(3, OP_MUL, 2'd2, 2'd3);
        expect_rsp(2'd3, 4'b0010);
        bus.req_valid = 4'b1000;
        wait_grant(4'b1000, "t4_first3");
        set_req(0, OP_NOT, 2'd2, 2'd0);
        expect_rsp(2'd0, 4'b0001);
        expect_rsp(2'd3, 4'b0010);
        bus.req_valid = 4'b1001;
        wait_grant(4'b0001, "t4_wrap0");
        wait_grant(4'b1000, "t4_then3");
        drain("t4_drain");

        // Reset in EXEC aborts the op: no response may ever appear
        bus.rsp_ready = 1'b1;
        set_req(1, OP_ADD, 2'd1, 2'd2);
        bus.req_valid = 4'b0010;
        wait_grant(4'b0010, "t5");
        check("t5_in_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

`ifdef ALU_SHARE_STATS_EN
        // Counters: 3 stall cycles, then enough ops to saturate stat_ops
        do_reset();
        set_req(0, OP_ADD, 2'd1, 2'd0);
        expect_rsp(2'd0, 4'b0001);
        bus.req_valid = 4'b0001;
        wait_grant(4'b0001, "st_first");
        wait_rsp_valid("st_rsp_valid");
        repeat (3) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stat_stall", 32'(stat_stall), 32'd3);
        drain("st_drain1");
        set_req(0, OP_ADD, 2'd1, 2'd1);
        for (int k = 0; k < 300; k++) begin
            expect_rsp(2'd0, 4'b0010);
            bus.req_valid = 4'b0001;
            wait_grant(4'b0001, "st_loop");
        end
        drain("st_drain2");
        @(negedge clk);
        check("stat_ops_sat", 32'(stat_ops), 32'd255);
        check("stat_stall_hold", 32'(stat_stall), 32'd3);
`endif

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
